// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types: register indices with special
// meaning, default stack/global pointer values and the basic word types.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_GP   = 5'd28;
    localparam reg_idx_t REG_SP   = 5'd29;

    localparam word_t DEF_SP_INIT = 32'h7FFF_EFFC;
    localparam word_t DEF_GP_INIT = 32'h1000_8000;

endpackage

// File: rtl/register_file_if.sv
// Register file bus: write port from the write-back muxes, two operand read
// ports towards the ALU, and a debug read port with the commit counter.
interface register_file_if #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
);
    logic              RegWrite;
    logic [ADDR_W-1:0] read_register_1;
    logic [ADDR_W-1:0] read_register_2;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] dbg_register;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] dbg_data;
    logic [31:0]       write_count;

    modport master (
        output RegWrite, read_register_1, read_register_2, write_register,
               write_data, dbg_register,
        input  read_data_1, read_data_2, dbg_data, write_count
    );

    modport slave (
        input  RegWrite, read_register_1, read_register_2, write_register,
               write_data, dbg_register,
        output read_data_1, read_data_2, dbg_data, write_count
    );
endinterface

// File: rtl/regfile_read_port.sv
// One operand read port: forces r0 to zero and optionally forwards the word
// being written this cycle so the reader sees it before the commit edge.
module regfile_read_port #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] rd_idx_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              reg_write_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic hit;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        hit       = 1'b0;
        rd_data_o = stored_i;
        if (BYPASS_EN && reg_write_i && !reset_i && (rd_idx_i == wr_idx_i)) begin
            hit = 1'b1;
        end
        if (rd_idx_i == '0) begin
            rd_data_o = '0;
        end else if (hit) begin
            rd_data_o = wr_data_i;
        end
    end
endmodule

// File: rtl/register_file.sv
// MIPS 32x32 general-purpose register file: r1..r31 storage with $gp/$sp
// reset values, two bypassable operand ports, a raw debug port and a commit counter.
module register_file #(
    parameter int                 DATA_W  = mips_pkg::DATA_W,
    parameter int                 ADDR_W  = mips_pkg::ADDR_W,
    parameter int                 BYPASS  = 1,
    parameter logic [DATA_W-1:0]  SP_INIT = mips_pkg::DEF_SP_INIT,
    parameter logic [DATA_W-1:0]  GP_INIT = mips_pkg::DEF_GP_INIT
) (
    input  logic          clock,
    input  logic          reset,
    register_file_if.slave bus
);
    import mips_pkg::REG_ZERO;
    import mips_pkg::REG_GP;
    import mips_pkg::REG_SP;

    localparam int REG_CNT = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [1:REG_CNT-1];
    logic [31:0]       write_count_q;
    logic [31:0]       write_count_d;
    logic              commit;
    logic [DATA_W-1:0] rs_word;
    logic [DATA_W-1:0] rt_word;

    // r0 has no storage, so any lookup that matches no register yields zero.
    function automatic logic [DATA_W-1:0] stored_word(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 1; i < REG_CNT; i++) begin
            if (idx == ADDR_W'(i)) begin
                w = regs_q[i];
            end
        end
        return w;
    endfunction

    assign commit        = bus.RegWrite && !reset && (bus.write_register != ADDR_W'(REG_ZERO));
    assign write_count_d = write_count_q + (commit ? 32'd1 : 32'd0);

    // NOTE: the storage array is reset on purpose: software relies on $gp/$sp and zeroed registers after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < REG_CNT; i++) begin
                if (i == int'(REG_GP)) begin
                    regs_q[i] <= GP_INIT;
                end else if (i == int'(REG_SP)) begin
                    regs_q[i] <= SP_INIT;
                end else begin
                    regs_q[i] <= '0;
                end
            end
            write_count_q <= '0;
        end else begin
            for (int i = 1; i < REG_CNT; i++) begin
                if (commit && (bus.write_register == ADDR_W'(i))) begin
                    regs_q[i] <= bus.write_data;
                end
            end
            write_count_q <= write_count_d;
        end
    end

    assign rs_word = stored_word(bus.read_register_1);
    assign rt_word = stored_word(bus.read_register_2);

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rs_port (
        .rd_idx_i    (bus.read_register_1),
        .stored_i    (rs_word),
        .reg_write_i (bus.RegWrite),
        .reset_i     (reset),
        .wr_idx_i    (bus.write_register),
        .wr_data_i   (bus.write_data),
        .rd_data_o   (bus.read_data_1)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rt_port (
        .rd_idx_i    (bus.read_register_2),
        .stored_i    (rt_word),
        .reg_write_i (bus.RegWrite),
        .reset_i     (reset),
        .wr_idx_i    (bus.write_register),
        .wr_data_i   (bus.write_data),
        .rd_data_o   (bus.read_data_2)
    );

    // The debug port shows committed contents only, never the in-flight write.
    assign bus.dbg_data    = stored_word(bus.dbg_register);
    assign bus.write_count = write_count_q;
endmodule
